load_store_unit: RTL and testbench

- Execute-stage consumer of the ALU result: takes the effective address from the ALU output (rs1 + imm) plus store data and access size.
- Runs a single-outstanding data-memory transaction with a req/gnt/rvalid handshake.
- Returns aligned, sign- or zero-extended load data to register writeback.
- Sits between the ALU and the data-memory port of the rysy core.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states,
// and the lane-offset and misalignment rules used for both bus and writeback paths.
package load_store_unit_pkg;

  localparam int REG_LEN = 32;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  // Byte lane an access starts on; offending low bits are dropped (half keeps
  // addr[1] only, word and the reserved size always use lane 0).
  function automatic logic [1:0] lsu_lane_off(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    case (size)
      LSU_SIZE_B: return addr_lo;
      LSU_SIZE_H: return {addr_lo[1], 1'b0};
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    case (size)
      LSU_SIZE_B: return 1'b0;
      LSU_SIZE_H: return addr_lo[0];
      default:    return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated store data,
// plus right-shift and sign/zero extension of returned load data.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]         st_size_i,
  input  logic [1:0]         st_off_i,
  input  logic [REG_LEN-1:0] st_wdata_i,
  input  logic [1:0]         ld_size_i,
  input  logic [1:0]         ld_off_i,
  input  logic               ld_unsigned_i,
  input  logic [REG_LEN-1:0] ld_rdata_i,
  output logic [3:0]         be_o,
  output logic [REG_LEN-1:0] wdata_o,
  output logic [REG_LEN-1:0] ld_data_o
);

  logic [REG_LEN-1:0] shifted;

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_wdata_i;
    case (st_size_i)
      LSU_SIZE_B: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_wdata_i[7:0]}};
      end
      LSU_SIZE_H: begin
        be_o    = 4'b0011 << st_off_i;
        wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = shifted;
    case (ld_size_i)
      LSU_SIZE_B: ld_data_o = {{(REG_LEN-8){~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
      LSU_SIZE_H: ld_data_o = {{(REG_LEN-16){~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with req/gnt/rvalid data-memory handshake.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being forced aligned.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RD_W   = 5,
  parameter int DATA_W = REG_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              busy
);

  lsu_state_e        state_q, state_d;
  logic              we_q, unsigned_q;
  logic [1:0]        size_q, off_q;
  logic [RD_W-1:0]   rd_q, wb_rd_q;
  logic [DATA_W-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
  logic [3:0]        mem_be_q;
  logic              done_q, done_d;
  logic              wb_valid_q, wb_valid_d;
  logic              capture, wb_load, req_trap;
  logic [1:0]        req_off;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c, ld_data_c;

  assign req_off = lsu_lane_off(req_size, req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign req_trap = lsu_misaligned(req_size, req_addr[1:0]);
  assign misalign = misalign_q;
`else
  assign req_trap = 1'b0;
`endif

  lsu_align u_align (
    .st_size_i     (req_size),
    .st_off_i      (req_off),
    .st_wdata_i    (req_wdata),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (unsigned_q),
    .ld_rdata_i    (mem_rdata),
    .be_o          (be_c),
    .wdata_o       (wdata_c),
    .ld_data_o     (ld_data_c)
  );

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    wb_load    = 1'b0;
    done_d     = 1'b0;
    wb_valid_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_trap) begin
            done_d = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`endif
          end else begin
            capture = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          wb_load    = 1'b1;
          wb_valid_d = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= LSU_SIZE_B;
      off_q       <= 2'b00;
      rd_q        <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_valid_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      done_q     <= done_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
      if (capture) begin
        we_q        <= req_we;
        unsigned_q  <= req_unsigned;
        size_q      <= req_size;
        off_q       <= req_off;
        rd_q        <= req_rd;
        mem_addr_q  <= {req_addr[DATA_W-1:2], 2'b00};
        mem_be_q    <= be_c;
        mem_wdata_q <= wdata_c;
      end
      if (wb_load) begin
        wb_data_q <= ld_data_c;
        wb_rd_q   <= rd_q;
      end
    end
  end

  // mem_req decodes straight from state so an async reset drops it immediately.
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit: bus and writeback expectations are
// queued when a request is driven and popped when the DUT presents them.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, done, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  bus_exp_t    bus_q[$];
  wb_exp_t     wb_q[$];
  int          n_run  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [31:0] last_wb = 32'h0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_rd       (req_rd),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .done         (done),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign     (misalign),
`endif
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
  endtask

  task automatic push_exp(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] wb);
    bus_exp_t b;
    wb_exp_t  w;
    b.addr = addr; b.be = be; b.wdata = wdata; b.we = we;
    bus_q.push_back(b);
    if (!we) begin
      w.rd = rd; w.data = wb;
      wb_q.push_back(w);
    end
  endtask

  // Drive one request, expect acceptance, leave the bench in the first REQ cycle.
  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_wb);
    push_exp(we, exp_addr, exp_be, exp_wdata, rd, exp_wb);
    drive_req(we, size, uns, addr, wdata, rd);
    check({tag, " req_ready"}, req_ready, 1'b1);
    cyc = 0;
    step();
    req_valid = 1'b0;
  endtask

  // Bus handshake from the first REQ cycle to the done cycle.
  task automatic bus_phase(input string tag, input int gnt_dly, input int rv_dly,
                           input logic [31:0] rdata);
    bus_exp_t b;
    wb_exp_t  w;
    check({tag, " bus sb"}, bus_q.size() != 0, 1'b1);
    if (bus_q.size() == 0) return;
    b = bus_q.pop_front();
    for (int i = 0; i < gnt_dly; i++) begin
      check({tag, " req held"}, mem_req, 1'b1);
      check({tag, " addr stable"}, mem_addr, b.addr);
      check({tag, " be stable"}, mem_be, b.be);
      check({tag, " ready low"}, req_ready, 1'b0);
      step();
    end
    mem_gnt = 1'b1;
    check({tag, " mem_req"}, mem_req, 1'b1);
    check({tag, " mem_addr"}, mem_addr, b.addr);
    check({tag, " mem_be"}, mem_be, b.be);
    check({tag, " mem_wdata"}, mem_wdata, b.wdata);
    check({tag, " mem_we"}, mem_we, b.we);
    step();
    mem_gnt = 1'b0;
    if (!b.we) begin
      for (int i = 0; i < rv_dly; i++) begin
        check({tag, " wait no req"}, mem_req, 1'b0);
        check({tag, " wait no wb"}, wb_valid, 1'b0);
        check({tag, " ready low"}, req_ready, 1'b0);
        step();
      end
      check({tag, " wait no done"}, done, 1'b0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      check({tag, " wb sb"}, wb_q.size() != 0, 1'b1);
      if (wb_q.size() == 0) return;
      w = wb_q.pop_front();
      check({tag, " wb_valid"}, wb_valid, 1'b1);
      check({tag, " done"}, done, 1'b1);
      check({tag, " wb_rd"}, wb_rd, w.rd);
      check({tag, " wb_data"}, wb_data, w.data);
      last_wb = w.data;
    end else begin
      check({tag, " done"}, done, 1'b1);
      check({tag, " no wb_valid"}, wb_valid, 1'b0);
      check({tag, " wb_data held"}, wb_data, last_wb);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) step();
    check("rst req_ready", req_ready, 1'b1);
    check("rst mem_req", mem_req, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst wb_valid", wb_valid, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_be", mem_be, 4'h0);
    rst_n = 1'b1;
    step();

    // SB: lane 3, replicated data, done at latency 2.
    issue("SB", 1'b1, LSU_SIZE_B, 1'b0, 32'h0000_1003, 32'h0000_00A5, 5'd0,
          32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    bus_phase("SB", 0, 0, 32'h0);
    check("SB latency", cyc, 2);
    step();
    check("SB done pulse", done, 1'b0);

    issue("LB", 1'b0, LSU_SIZE_B, 1'b0, 32'h0000_2002, 32'h0, 5'd7,
          32'h0000_2000, 4'b0100, 32'h0, 32'hFFFF_FF80);
    bus_phase("LB", 0, 0, 32'h0080_0000);
    check("LB latency", cyc, 3);
    step();
    check("LB wb pulse", wb_valid, 1'b0);
    check("LB wb hold", wb_data, 32'hFFFF_FF80);

    issue("LBU", 1'b0, LSU_SIZE_B, 1'b1, 32'h0000_2002, 32'h0, 5'd9,
          32'h0000_2000, 4'b0100, 32'h0, 32'h0000_0080);
    bus_phase("LBU", 0, 0, 32'h0080_0000);

    // LH with three gnt wait-states: mem_req held four cycles.
    issue("LH", 1'b0, LSU_SIZE_H, 1'b0, 32'h0000_2002, 32'h0, 5'd12,
          32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001);
    bus_phase("LH", 3, 0, 32'h8001_1234);
    check("LH latency", cyc, 6);

    issue("LHU", 1'b0, LSU_SIZE_H, 1'b1, 32'h0000_4000, 32'h0, 5'd4,
          32'h0000_4000, 4'b0011, 32'h0, 32'h0000_F00F);
    bus_phase("LHU", 0, 2, 32'h1234_F00F);
    check("LHU latency", cyc, 5);

    issue("SH", 1'b1, LSU_SIZE_H, 1'b0, 32'h0000_0012, 32'h1234_BEEF, 5'd0,
          32'h0000_0010, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    bus_phase("SH", 1, 0, 32'h0);

    issue("SW", 1'b1, LSU_SIZE_W, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 5'd0,
          32'h0000_0020, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    bus_phase("SW", 0, 0, 32'h0);

    // Back-to-back: second request held high across the first load.
    push_exp(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 5'd3, 32'hCAFE_F00D);
    drive_req(1'b0, LSU_SIZE_W, 1'b0, 32'h0000_0100, 32'h0, 5'd3);
    check("B2B A ready", req_ready, 1'b1);
    cyc = 0;
    step();
    drive_req(1'b1, LSU_SIZE_B, 1'b0, 32'h0000_0201, 32'h0000_005A, 5'd0);
    check("B2B ready low", req_ready, 1'b0);
    bus_phase("B2B A", 1, 1, 32'hCAFE_F00D);
    check("B2B ready in done", req_ready, 1'b1);
    push_exp(1'b1, 32'h0000_0200, 4'b0010, 32'h5A5A_5A5A, 5'd0, 32'h0);
    cyc = 0;
    step();
    req_valid = 1'b0;
    check("B2B B accepted", busy, 1'b1);
    bus_phase("B2B B", 0, 0, 32'h0);
    check("B2B B latency", cyc, 2);
    step();

    // Reset in REQ drops mem_req without waiting for a clock edge.
    issue("RSTREQ", 1'b0, LSU_SIZE_W, 1'b0, 32'h0000_0400, 32'h0, 5'd1,
          32'h0000_0400, 4'b1111, 32'h0, 32'h0);
    check("RSTREQ mem_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("RSTREQ async drop", mem_req, 1'b0);
    check("RSTREQ async idle", req_ready, 1'b1);
    bus_q.delete();
    wb_q.delete();
    #2;
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    check("IDLE ignores gnt", busy, 1'b0);
    check("IDLE ignores rvalid", wb_valid, 1'b0);

    // Reset in WAIT, then a late rvalid.
    issue("RSTWAIT", 1'b0, LSU_SIZE_W, 1'b0, 32'h0000_0500, 32'h0, 5'd2,
          32'h0000_0500, 4'b1111, 32'h0, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("RSTWAIT in wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("RSTWAIT idle", busy, 1'b0);
    check("RSTWAIT mem_req", mem_req, 1'b0);
    check("RSTWAIT wb_data clr", wb_data, 32'h0);
    bus_q.delete();
    wb_q.delete();
    last_wb = 32'h0;
    #2;
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    step();
    mem_rvalid = 1'b0;
    check("RSTWAIT late rvalid wb", wb_valid, 1'b0);
    check("RSTWAIT late rvalid done", done, 1'b0);
    step();
    check("RSTWAIT no wb later", wb_valid, 1'b0);
    check("RSTWAIT data kept", wb_data, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    drive_req(1'b0, LSU_SIZE_W, 1'b0, 32'h0000_3002, 32'h0, 5'd5);
    check("MIS ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    check("MIS misalign", misalign, 1'b1);
    check("MIS done", done, 1'b1);
    check("MIS no req", mem_req, 1'b0);
    check("MIS idle", busy, 1'b0);
    check("MIS no wb", wb_valid, 1'b0);
    step();
    check("MIS pulse", misalign, 1'b0);
    check("MIS done pulse", done, 1'b0);
    check("MIS still no req", mem_req, 1'b0);
`else
    issue("LWMIS", 1'b0, LSU_SIZE_W, 1'b0, 32'h0000_3002, 32'h0, 5'd5,
          32'h0000_3000, 4'b1111, 32'h0, 32'h1122_3344);
    bus_phase("LWMIS", 0, 0, 32'h1122_3344);
    issue("LHMIS", 1'b0, LSU_SIZE_H, 1'b0, 32'h0000_3003, 32'h0, 5'd6,
          32'h0000_3000, 4'b1100, 32'h0, 32'h0000_1122);
    bus_phase("LHMIS", 0, 0, 32'h1122_3344);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
